instr_mem_loadable: RTL and testbench

Parametrised, synchronous-read instruction memory for the project CPU, replacing the hard-wired combinational ROM. Each fetch returns an instruction word plus the following immediate word. A byte-stream loader port, normally fed by the UART receiver, can overwrite the memory at run time. The loader frames, writes and checksums a program image and asserts `busy` so the top level can hold the CPU in reset while a load is in progress.

---
 rtl/project_pkg.sv | 13 +
 rtl/imem_loader_fsm.sv | 98 +++++++++
 rtl/instr_mem_loadable.sv | 78 +++++++
 tb/tb_instr_mem_loadable.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/project_pkg.sv
// rtl/project_pkg.sv - shared constants and types for the project CPU
package project_pkg;

  localparam logic [7:0] LD_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LEN,
    LD_DATA,
    LD_CSUM
  } ld_state_e;

endpackage

// File: rtl/imem_loader_fsm.sv
// rtl/imem_loader_fsm.sv - framed byte-stream loader with checksum for the instruction memory
module imem_loader_fsm
  import project_pkg::*;
#(
  parameter int              WORD  = 8,
  parameter int              DEPTH = 256,
  parameter int              AW    = $clog2(DEPTH),
  parameter logic [WORD-1:0] SYNC  = WORD'(LD_SYNC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  input  logic [WORD-1:0] ld_data,
  output logic            ld_ready,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            we,
  output logic [AW-1:0]   waddr,
  output logic [WORD-1:0] wdata
);

  ld_state_e       r_state;
  logic [WORD-1:0] r_cnt;
  logic [WORD-1:0] r_sum;
  logic [AW-1:0]   r_ptr;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic            w_xfer;
  logic [AW-1:0]   w_ptr_next;

  assign w_xfer     = ld_valid && r_ready;
  // Explicit wrap keeps the pointer inside the array for non-power-of-two depths.
  assign w_ptr_next = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;

  assign we       = w_xfer && (r_state == LD_DATA);
  assign waddr    = r_ptr;
  assign wdata    = ld_data;
  assign ld_ready = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LD_IDLE;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ptr   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          LD_IDLE: begin
            if (ld_data == SYNC) begin
              r_state <= LD_LEN;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
            end
          end
          LD_LEN: begin
            r_cnt   <= ld_data;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_state <= (ld_data == '0) ? LD_CSUM : LD_DATA;
          end
          LD_DATA: begin
            r_ptr <= w_ptr_next;
            r_sum <= r_sum + ld_data;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == WORD'(1)) begin
              r_state <= LD_CSUM;
            end
          end
          LD_CSUM: begin
            if (ld_data == r_sum) begin
              r_done <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= LD_IDLE;
          end
          default: r_state <= LD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - synchronous-read instruction memory with run-time byte-stream loader
module instr_mem_loadable
  import project_pkg::*;
#(
  parameter int              WORD      = 8,
  parameter int              DEPTH     = 256,
  parameter logic [WORD-1:0] SYNC      = WORD'(LD_SYNC),
  parameter string           INIT_FILE = "",
  localparam int             AW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic [AW-1:0]   addr,
  output logic [WORD-1:0] instr,
  output logic [WORD-1:0] imm,
  input  logic            ld_valid,
  input  logic [WORD-1:0] ld_data,
  output logic            ld_ready,
  output logic            busy,
  output logic            done,
  output logic            err
);

  logic [WORD-1:0] r_mem [DEPTH];
  logic [WORD-1:0] r_instr;
  logic [WORD-1:0] r_imm;

  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [WORD-1:0] w_wdata;
  logic [AW-1:0]   w_addr_next;

  imem_loader_fsm #(
    .WORD  (WORD),
    .DEPTH (DEPTH),
    .AW    (AW),
    .SYNC  (SYNC)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .we       (w_we),
    .waddr    (w_waddr),
    .wdata    (w_wdata)
  );

  assign w_addr_next = (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // The CPU is held in reset while busy, so NOPs are fed rather than half-loaded code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= '0;
      r_imm   <= '0;
    end else if (busy) begin
      r_instr <= '0;
      r_imm   <= '0;
    end else if (fetch_en) begin
      r_instr <= r_mem[addr];
      r_imm   <= r_mem[w_addr_next];
    end
  end

  assign instr = r_instr;
  assign imm   = r_imm;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - self-checking bench for instr_mem_loadable
module tb_instr_mem_loadable;

  localparam int WORD  = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    string      name;
    logic [7:0] ins;
    logic [7:0] imm;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    bit            en;
    logic [7:0]    ei;
    logic [7:0]    em;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            fetch_en;
  logic [AW-1:0]   addr;
  logic [WORD-1:0] instr;
  logic [WORD-1:0] imm;
  logic            ld_valid;
  logic [WORD-1:0] ld_data;
  logic            ld_ready;
  logic            busy;
  logic            done;
  logic            err;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vt[7];

  instr_mem_loadable #(
    .WORD  (WORD),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_en (fetch_en),
    .addr     (addr),
    .instr    (instr),
    .imm      (imm),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bq_t make_frame(input bq_t p);
    bq_t        f;
    logic [7:0] s;
    s = 8'h00;
    f.push_back(8'hA5);
    f.push_back(8'(p.size()));
    foreach (p[i]) begin
      f.push_back(p[i]);
      s = s + p[i];
    end
    f.push_back(s);
    return f;
  endfunction

  task automatic send_word(input logic [7:0] w);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string name, input bq_t f, input bit good);
    int last;
    last = f.size() - 1;
    for (int i = 0; i <= last; i++) begin
      check({name, " ld_ready"}, ld_ready, 1);
      send_word(f[i]);
      check({name, " busy"}, busy, (i != last));
      check({name, " done"}, done, (i == last) && good);
      check({name, " err"}, err, (i == last) && !good);
      if (fetch_en && i >= 1) begin
        check({name, " nop instr"}, instr, 0);
        check({name, " nop imm"}, imm, 0);
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, done, 0);
    check({name, " busy after"}, busy, 0);
    check({name, " err sticky"}, err, !good);
  endtask

  task automatic fetch_step(input string name, input logic [AW-1:0] a, input bit en,
                            input logic [7:0] ei, input logic [7:0] em);
    exp_t e;
    @(negedge clk);
    addr     = a;
    fetch_en = en;
    sb.push_back('{name: name, ins: ei, imm: em});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, " instr"}, instr, e.ins);
    check({e.name, " imm"}, imm, e.imm);
  endtask

  initial begin
    bq_t p;
    bq_t f;

    vt[0] = '{a: 4'd1,  en: 1'b1, ei: 8'h10, em: 8'hFF};
    vt[1] = '{a: 4'd2,  en: 1'b0, ei: 8'h10, em: 8'hFF};
    vt[2] = '{a: 4'd15, en: 1'b1, ei: 8'h4F, em: 8'h00};
    vt[3] = '{a: 4'd3,  en: 1'b1, ei: 8'h20, em: 8'h44};
    vt[4] = '{a: 4'd0,  en: 1'b1, ei: 8'h00, em: 8'h10};
    vt[5] = '{a: 4'd7,  en: 1'b0, ei: 8'h00, em: 8'h10};
    vt[6] = '{a: 4'd14, en: 1'b1, ei: 8'h4E, em: 8'h4F};

    rst      = 1'b1;
    fetch_en = 1'b0;
    addr     = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset instr", instr, 0);
    check("reset imm", imm, 0);
    check("reset ld_ready", ld_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ld_ready after reset", ld_ready, 1);

    // Program image: 00,10,FF,20 followed by 44..4F filling the whole array.
    p = {8'h00, 8'h10, 8'hFF, 8'h20};
    for (int i = 4; i < DEPTH; i++) p.push_back(8'(8'h40 + i));
    send_frame("image", make_frame(p), 1'b1);

    foreach (vt[i]) fetch_step($sformatf("vec%0d", i), vt[i].a, vt[i].en, vt[i].ei, vt[i].em);

    @(negedge clk);
    addr     = 4'd1;
    fetch_en = 1'b1;
    send_frame("frameA", '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66}, 1'b1);
    check("after A refetch instr", instr, 8'h22);
    fetch_step("A addr0", 4'd0, 1'b1, 8'h11, 8'h22);
    fetch_step("A addr3", 4'd3, 1'b1, 8'h20, 8'h44);
    fetch_en = 1'b0;

    send_frame("bad", '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h04}, 1'b0);
    fetch_step("bad addr0", 4'd0, 1'b1, 8'h01, 8'h02);
    fetch_en = 1'b0;
    send_frame("clear err", '{8'hA5, 8'h01, 8'h5A, 8'h5A}, 1'b1);

    send_word(8'h00);
    check("garbage 00 busy", busy, 0);
    send_word(8'hFF);
    check("garbage FF busy", busy, 0);
    send_frame("empty", '{8'hA5, 8'h00, 8'h00}, 1'b1);
    fetch_step("empty addr0", 4'd0, 1'b1, 8'h5A, 8'h02);

    send_frame("sync in data", '{8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA6}, 1'b1);
    fetch_step("sync data addr0", 4'd0, 1'b1, 8'hA5, 8'h01);
    fetch_en = 1'b0;

    p = {};
    for (int i = 0; i < 17; i++) p.push_back(8'(8'h80 + i));
    send_frame("wrap", make_frame(p), 1'b1);
    fetch_step("wrap addr0", 4'd0, 1'b1, 8'h90, 8'h81);
    fetch_step("wrap addr15", 4'd15, 1'b1, 8'h8F, 8'h90);
    fetch_en = 1'b0;

    send_word(8'hA5);
    send_word(8'h04);
    send_word(8'h11);
    check("midframe busy", busy, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset ld_ready", ld_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post reset done", done, 0);
      check("post reset err", err, 0);
      check("post reset busy", busy, 0);
    end
    fetch_step("mid reset addr0", 4'd0, 1'b1, 8'h11, 8'h81);
    fetch_en = 1'b0;
    send_frame("idle after reset", '{8'hA5, 8'h00, 8'h00}, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
